// File: rtl/sdes_pkg.sv
// S-DES constants shared by the decrypt core: FSM state type, permutation
// tables (1-based, leftmost bit = 1), S-box contents and small helpers.
package sdes_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StKeygen,
    StRound1,
    StRound2,
    StDone
  } sdes_state_e;

  localparam int P10Tbl   [10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
  localparam int P8Tbl    [8]  = '{6, 3, 7, 4, 8, 5, 10, 9};
  localparam int IpTbl    [8]  = '{2, 6, 3, 1, 4, 8, 5, 7};
  localparam int IpInvTbl [8]  = '{4, 1, 3, 5, 7, 2, 8, 6};
  localparam int EpTbl    [8]  = '{4, 1, 2, 3, 2, 3, 4, 1};
  localparam int P4Tbl    [4]  = '{2, 4, 3, 1};

  // Indexed [row][column].
  localparam logic [1:0] S0Tbl [4][4] = '{
    '{2'd1, 2'd0, 2'd3, 2'd2},
    '{2'd3, 2'd2, 2'd1, 2'd0},
    '{2'd0, 2'd2, 2'd1, 2'd3},
    '{2'd3, 2'd1, 2'd3, 2'd2}
  };
  localparam logic [1:0] S1Tbl [4][4] = '{
    '{2'd0, 2'd1, 2'd2, 2'd3},
    '{2'd2, 2'd0, 2'd1, 2'd3},
    '{2'd3, 2'd0, 2'd1, 2'd0},
    '{2'd2, 2'd1, 2'd0, 2'd3}
  };

  function automatic logic [0:9] perm_p10(input logic [0:9] k);
    logic [0:9] r;
    for (int i = 0; i < 10; i++) r[i] = k[P10Tbl[i]-1];
    return r;
  endfunction

  function automatic logic [0:7] perm_p8(input logic [0:9] k);
    logic [0:7] r;
    for (int i = 0; i < 8; i++) r[i] = k[P8Tbl[i]-1];
    return r;
  endfunction

  function automatic logic [0:7] perm_ip(input logic [0:7] d);
    logic [0:7] r;
    for (int i = 0; i < 8; i++) r[i] = d[IpTbl[i]-1];
    return r;
  endfunction

  function automatic logic [0:7] perm_ip_inv(input logic [0:7] d);
    logic [0:7] r;
    for (int i = 0; i < 8; i++) r[i] = d[IpInvTbl[i]-1];
    return r;
  endfunction

  function automatic logic [0:7] perm_ep(input logic [0:3] d);
    logic [0:7] r;
    for (int i = 0; i < 8; i++) r[i] = d[EpTbl[i]-1];
    return r;
  endfunction

  function automatic logic [0:3] perm_p4(input logic [0:3] d);
    logic [0:3] r;
    for (int i = 0; i < 4; i++) r[i] = d[P4Tbl[i]-1];
    return r;
  endfunction

  // Left rotations of a 5-bit key half.
  function automatic logic [0:4] ls1(input logic [0:4] h);
    return {h[1:4], h[0]};
  endfunction

  function automatic logic [0:4] ls2(input logic [0:4] h);
    return {h[2:4], h[0:1]};
  endfunction

  // Row from outer bits (1,4), column from inner bits (2,3).
  function automatic logic [1:0] s0_lookup(input logic [0:3] x);
    return S0Tbl[{x[0], x[3]}][{x[1], x[2]}];
  endfunction

  function automatic logic [1:0] s1_lookup(input logic [0:3] x);
    return S1Tbl[{x[0], x[3]}][{x[1], x[2]}];
  endfunction

endpackage

// File: rtl/sdes_decrypt_core_fk.sv
// S-DES round function Fk: combinational, left half mixed, right half passed.
module sdes_fk (
  input  logic [0:7] data_i,
  input  logic [0:7] subkey_i,
  output logic [0:7] data_o
);
  import sdes_pkg::*;

  logic [0:7] mixed;
  logic [0:3] sbox_out;

  // Expand right half, key it, substitute, permute and fold into left half.
  always_comb begin
    mixed    = perm_ep(data_i[4:7]) ^ subkey_i;
    sbox_out = {s0_lookup(mixed[0:3]), s1_lookup(mixed[4:7])};
    data_o   = {data_i[0:3] ^ perm_p4(sbox_out), data_i[4:7]};
  end

endmodule

// File: rtl/sdes_decrypt_core.sv
// S-DES decryption engine: one job at a time, fixed 4-edge latency from
// accept to out_valid, result held until the consumer takes it.
module sdes_decrypt_core (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [0:9] key,
  input  logic [0:7] cipher_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [0:7] plain_out,
  output logic       busy
);
  import sdes_pkg::*;

  sdes_state_e state_q, state_d;

  logic [0:9] key_q, key_d;
  logic [0:7] data_q, data_d;
  logic [0:7] k1_q, k1_d;
  logic [0:7] k2_q, k2_d;
  logic [0:7] plain_q, plain_d;

  logic [0:9] p10_key;
  logic [0:4] half_l1, half_r1;
  logic [0:7] fk_subkey, fk_out;

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: fixed walk through the rounds, wait in DONE for the consumer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (in_valid) state_d = StKeygen;
      StKeygen: state_d = StRound1;
      StRound1: state_d = StRound2;
      StRound2: state_d = StDone;
      StDone:   if (out_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Handshake and status outputs are pure functions of the state.
  always_comb begin
    in_ready  = (state_q == StIdle);
    busy      = (state_q != StIdle);
    out_valid = (state_q == StDone);
    plain_out = plain_q;
  end

  // Key schedule front end: P10 then LS-1 on each half (shared by K1 and K2).
  always_comb begin
    p10_key = perm_p10(key_q);
    half_l1 = ls1(p10_key[0:4]);
    half_r1 = ls1(p10_key[5:9]);
  end

  // Decryption applies K2 first, then K1; one Fk instance serves both rounds.
  always_comb begin
    fk_subkey = (state_q == StRound1) ? k2_q : k1_q;
  end

  sdes_fk u_fk (
    .data_i   (data_q),
    .subkey_i (fk_subkey),
    .data_o   (fk_out)
  );

  // Datapath next-state: capture on accept, then one transform per state.
  always_comb begin
    key_d   = key_q;
    data_d  = data_q;
    k1_d    = k1_q;
    k2_d    = k2_q;
    plain_d = plain_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          key_d  = key;
          data_d = cipher_in;
        end
      end
      StKeygen: begin
        k1_d   = perm_p8({half_l1, half_r1});
        k2_d   = perm_p8({ls2(half_l1), ls2(half_r1)});
        data_d = perm_ip(data_q);
      end
      StRound1: begin
        data_d = {fk_out[4:7], fk_out[0:3]};
      end
      StRound2: begin
        plain_d = perm_ip_inv(fk_out);
      end
      default: ;
    endcase
  end

  // Datapath registers; reset wipes key material as well as the result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_q   <= '0;
      data_q  <= '0;
      k1_q    <= '0;
      k2_q    <= '0;
      plain_q <= '0;
    end else begin
      key_q   <= key_d;
      data_q  <= data_d;
      k1_q    <= k1_d;
      k2_q    <= k2_d;
      plain_q <= plain_d;
    end
  end

endmodule
